// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-facing bus of the register file: two read ports with busy flags,
// an issue port that marks destinations busy, and the writeback port.
interface regfile_scoreboard_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [AW-1:0]   ra1;
    logic [AW-1:0]   ra2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            busy1;
    logic            busy2;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;

    modport master (
        output ra1, ra2, issue_valid, issue_rd, we, waddr, wdata,
        input  rd1, rd2, busy1, busy2
    );

    modport slave (
        input  ra1, ra2, issue_valid, issue_rd, we, waddr, wdata,
        output rd1, rd2, busy1, busy2
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Resettable integer register file with two combinational read ports and a per-register busy
// scoreboard. Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_scoreboard_if.slave bus
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [XLEN-1:0]  rd1_q;
    logic [XLEN-1:0]  rd2_q;
    logic             busy1_q;
    logic             busy2_q;

    function automatic logic writable(input int idx);
        return !(ZERO_REG != 0 && idx == 0);
    endfunction

`ifdef REGFILE_BYPASS_EN
    function automatic logic legal_addr(input logic [AW-1:0] a);
        return (int'(a) < NREGS) && writable(int'(a));
    endfunction
`endif

    // Addresses at or beyond NREGS never match any index, so they are dropped naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (bus.we && bus.waddr == AW'(i) && writable(i)) begin
                    regs[i] <= bus.wdata;
                end
            end
        end
    end

    // A same-cycle issue to the completing register means a newer producer exists, so set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (bus.issue_valid && bus.issue_rd == AW'(i) && writable(i)) begin
                    busy[i] <= 1'b1;
                end else if (bus.we && bus.waddr == AW'(i)) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rd1_q   = '0;
        rd2_q   = '0;
        busy1_q = 1'b0;
        busy2_q = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (writable(i)) begin
                if (bus.ra1 == AW'(i)) begin
                    rd1_q   = regs[i];
                    busy1_q = busy[i];
                end
                if (bus.ra2 == AW'(i)) begin
                    rd2_q   = regs[i];
                    busy2_q = busy[i];
                end
            end
        end
`ifdef REGFILE_BYPASS_EN
        // Forwarded data is complete, so busy drops unless a new producer issues this cycle.
        if (bus.we && legal_addr(bus.waddr)) begin
            if (bus.waddr == bus.ra1) begin
                rd1_q = bus.wdata;
                if (!(bus.issue_valid && bus.issue_rd == bus.ra1)) begin
                    busy1_q = 1'b0;
                end
            end
            if (bus.waddr == bus.ra2) begin
                rd2_q = bus.wdata;
                if (!(bus.issue_valid && bus.issue_rd == bus.ra2)) begin
                    busy2_q = 1'b0;
                end
            end
        end
`endif
    end

    assign bus.rd1   = rd1_q;
    assign bus.rd2   = rd2_q;
    assign bus.busy1 = busy1_q;
    assign bus.busy2 = busy2_q;

endmodule
